// File: rtl/vga_pkg.sv
// ============================================================================
// Module : vga_pkg
// Brief  : SVGA 800x600@60 timing totals and vblank-update arbiter types.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

package vga_pkg;

  localparam int HOR_TOTAL_TIME = 1056;
  localparam int VER_TOTAL_TIME = 628;

  localparam int VUPD_CNT_W = 4;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    WINDOW = 2'd1,
    DRAIN  = 2'd2,
    COMMIT = 2'd3
  } vupd_state_t;

endpackage

`default_nettype wire

// File: rtl/vga_vblank_update_arbiter_rr.sv
// ============================================================================
// Module : rr_arbiter
// Brief  : Combinational round-robin pick: first set request at or after ptr.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module rr_arbiter #(
  parameter int N     = 4,
  parameter int PTR_W = $clog2(N)
) (
  input  logic [N-1:0]     req,
  input  logic [PTR_W-1:0] ptr,
  output logic [N-1:0]     winner
);

  localparam int SUM_W = PTR_W + 1;
  localparam logic [SUM_W-1:0] C_N = SUM_W'(N);

  logic [SUM_W-1:0] w_sum;
  logic [PTR_W-1:0] w_idx;
  logic             w_found;

  always_comb begin
    winner  = '0;
    w_found = 1'b0;
    w_sum   = '0;
    w_idx   = '0;
    for (int k = 0; k < N; k++) begin
      // wrap ptr+k into 0..N-1 without a modulo operator
      w_sum = {1'b0, ptr} + SUM_W'(k);
      if (w_sum >= C_N) w_sum = w_sum - C_N;
      w_idx = w_sum[PTR_W-1:0];
      if (!w_found && req[w_idx]) begin
        winner[w_idx] = 1'b1;
        w_found       = 1'b1;
      end
    end
  end

endmodule

`default_nettype wire

// File: rtl/vga_vblank_update_arbiter.sv
// ============================================================================
// Module : vga_vblank_update_arbiter
// Brief  : Grants parameter-register updates during vblank, commits at frame end.
// Rev    : 1.0  initial release
// ============================================================================
`default_nettype none

module vga_vblank_update_arbiter
  import vga_pkg::*;
#(
  parameter int N_REQ   = 4,
  parameter int DATA_W  = 32,
  parameter int MAX_GNT = N_REQ
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [10:0]             hcount,
  input  logic [10:0]             vcount,
  input  logic                    vblnk,
  input  logic [N_REQ-1:0]        req,
  input  logic [N_REQ*DATA_W-1:0] wr_data,
  output logic [N_REQ-1:0]        gnt,
  output logic [DATA_W-1:0]       active_data,
  output logic                    frame_start,
  output logic                    window_open
);

  localparam int PTR_W = $clog2(N_REQ);
  localparam logic [10:0]           C_H_LAST  = 11'(HOR_TOTAL_TIME - 1);
  localparam logic [10:0]           C_V_LAST  = 11'(VER_TOTAL_TIME - 1);
  localparam logic [VUPD_CNT_W-1:0] C_CNT_MAX = VUPD_CNT_W'(MAX_GNT);
  localparam logic [PTR_W-1:0]      C_PTR_TOP = PTR_W'(N_REQ - 1);

  vupd_state_t           r_state, w_state_nxt;
  logic                  r_vblnk_d;
  logic [PTR_W-1:0]      r_ptr;
  logic [VUPD_CNT_W-1:0] r_cnt;
  logic [DATA_W-1:0]     r_shadow;
  logic [DATA_W-1:0]     r_active;
  logic [N_REQ-1:0]      r_gnt;
  logic                  r_frame_start;

  logic [N_REQ-1:0]  w_winner;
  logic [PTR_W-1:0]  w_gnt_idx;
  logic [DATA_W-1:0] w_words [N_REQ];
  logic              w_vblnk_rise, w_guard, w_last_pix, w_cnt_full, w_arb_en, w_commit;

  for (genvar gi = 0; gi < N_REQ; gi++) begin : g_words
    assign w_words[gi] = wr_data[gi*DATA_W +: DATA_W];
  end

  assign w_vblnk_rise = vblnk & ~r_vblnk_d;
  assign w_guard      = (vcount == C_V_LAST) && (hcount == 11'd0);
  assign w_last_pix   = (vcount == C_V_LAST) && (hcount == C_H_LAST);
  assign w_cnt_full   = (r_cnt >= C_CNT_MAX);
  assign w_commit     = (r_state == DRAIN) && w_last_pix;
  // the rising-edge cycle itself arbitrates, so the first gnt lands on hcount+1
  assign w_arb_en     = ((r_state == IDLE) && w_vblnk_rise) ||
                        ((r_state == WINDOW) && !w_cnt_full && !w_guard);

  rr_arbiter #(.N(N_REQ), .PTR_W(PTR_W)) u_rr (
    .req    (req & ~r_gnt),
    .ptr    (r_ptr),
    .winner (w_winner)
  );

  always_comb begin
    w_gnt_idx = '0;
    for (int i = 0; i < N_REQ; i++) begin
      if (r_gnt[i]) w_gnt_idx = PTR_W'(i);
    end
  end

  always_comb begin
    w_state_nxt = r_state;
    case (r_state)
      IDLE:    if (w_vblnk_rise) w_state_nxt = WINDOW;
      WINDOW:  if (w_cnt_full || w_guard) w_state_nxt = DRAIN;
      DRAIN:   if (w_last_pix) w_state_nxt = COMMIT;
      COMMIT:  w_state_nxt = IDLE;
      default: w_state_nxt = IDLE;
    endcase
  end

  // tracks vblnk through reset so a release inside vblank never opens a window
  always_ff @(posedge clk) begin
    r_vblnk_d <= vblnk;
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= IDLE;
      r_gnt         <= '0;
      r_ptr         <= '0;
      r_cnt         <= '0;
      r_shadow      <= '0;
      r_active      <= '0;
      r_frame_start <= 1'b0;
    end else begin
      r_state       <= w_state_nxt;
      r_gnt         <= w_arb_en ? w_winner : '0;
      r_frame_start <= w_commit;
      if ((r_state == IDLE) && w_vblnk_rise)
        r_cnt <= (|w_winner) ? VUPD_CNT_W'(1) : '0;
      else if (w_arb_en && (|w_winner))
        r_cnt <= r_cnt + VUPD_CNT_W'(1);
      if (|r_gnt) begin
        r_shadow <= w_words[w_gnt_idx];
        r_ptr    <= (w_gnt_idx == C_PTR_TOP) ? '0 : w_gnt_idx + PTR_W'(1);
      end
      if (w_commit) r_active <= r_shadow;
    end
  end

  assign gnt         = r_gnt;
  assign active_data = r_active;
  assign frame_start = r_frame_start;
  assign window_open = (r_state == WINDOW);

endmodule

`default_nettype wire
